// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// start/busy/done handshake; divide-by-zero reported in a single cycle.
module restoring_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH:0]   work_r;
  logic [WIDTH-1:0] work_q;
  logic [WIDTH-1:0] work_d;
  logic [CW-1:0]    count;

  logic [2*WIDTH:0] sh;
  logic [WIDTH:0]   r_sh;
  logic [WIDTH-1:0] q_sh;
  logic [WIDTH:0]   t;
  logic [WIDTH:0]   r_nx;
  logic [WIDTH-1:0] q_nx;
  logic             last;
  logic             accept;
  logic             dz;

  always_comb begin
    sh   = {work_r, work_q} << 1;
    r_sh = sh[2*WIDTH:WIDTH];
    q_sh = sh[WIDTH-1:0];
    t    = r_sh - {1'b0, work_d};
    r_nx = r_sh;
    q_nx = q_sh;
    // borrow clear: trial subtraction fits, keep it
    if (!t[WIDTH]) begin
      r_nx = t;
      q_nx = {q_sh[WIDTH-1:1], 1'b1};
    end
  end

  assign last   = (count == CW'(WIDTH - 1));
  assign accept = (state == IDLE) && start;
  assign dz     = (divisor == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nx = dz ? DONE : CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_r      <= '0;
      work_q      <= '0;
      work_d      <= '0;
      count       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      if (dz) begin
        quotient    <= '1;
        remainder   <= dividend;
        div_by_zero <= 1'b1;
      end else begin
        work_q <= dividend;
        work_r <= '0;
        work_d <= divisor;
        count  <= '0;
      end
    end else if (state == CALC) begin
      work_r <= r_nx;
      work_q <= q_nx;
      count  <= count + 1'b1;
      if (last) begin
        quotient    <= q_nx;
        remainder   <= r_nx[WIDTH-1:0];
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_restoring_divider.sv
// Self-checking bench for restoring_divider (WIDTH=4).
// Reference results come from plain / and % arithmetic.
module tb_restoring_divider;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int checks = 0;
  int failures = 0;

  int hq = 0;
  int hr = 0;
  int hz = 0;

  always #5 clk = ~clk;

  restoring_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  task automatic check(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int a, input int b, input bit poke);
    int  n;
    int  nb;
    int  eq;
    int  er;
    int  ez;
    int  lat;
    bit  got;
    eq  = (b == 0) ? (1 << W) - 1 : a / b;
    er  = (b == 0) ? a : a % b;
    ez  = (b == 0) ? 1 : 0;
    lat = (b == 0) ? 0 : W;
    dividend = W'(a);
    divisor  = W'(b);
    start    = 1'b1;
    tick();
    start    = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
    n  = 0;
    nb = 0;
    got = done;
    while (!got && n < 20) begin
      if (busy) nb++;
      check("hold_q", int'(quotient), hq);
      check("hold_r", int'(remainder), hr);
      check("hold_z", int'(div_by_zero), hz);
      if (poke && n == 1) begin
        start    = 1'b1;
        dividend = 4'd7;
        divisor  = 4'd7;
      end else begin
        start = 1'b0;
      end
      tick();
      n++;
      got = done;
    end
    start = 1'b0;
    check("timeout", int'(got), 1);
    check("latency", n, lat);
    check("busy_cycles", nb, lat);
    check("busy_at_done", int'(busy), 0);
    check("quotient", int'(quotient), eq);
    check("remainder", int'(remainder), er);
    check("dbz", int'(div_by_zero), ez);
    hq = eq;
    hr = er;
    hz = ez;
    tick();
    check("done_pulse", int'(done), 0);
    check("idle_busy", int'(busy), 0);
    check("after_q", int'(quotient), hq);
    check("after_r", int'(remainder), hr);
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) tick();
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_q", int'(quotient), 0);
    check("rst_r", int'(remainder), 0);
    check("rst_z", int'(div_by_zero), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    run(13, 3, 1'b0);
    run(15, 1, 1'b0);
    run(2, 7, 1'b0);
    run(15, 15, 1'b0);
    run(5, 0, 1'b0);
    run(9, 2, 1'b0);
    run(13, 3, 1'b1);

    // abort mid-operation with reset
    dividend = 4'd14;
    divisor  = 4'd4;
    start    = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("pre_abort_busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_q", int'(quotient), 0);
    check("abort_r", int'(remainder), 0);
    hq = 0;
    hr = 0;
    hz = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("abort_no_done", int'(done), 0);
      check("abort_no_busy", int'(busy), 0);
    end
    run(14, 4, 1'b0);

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        run(a, b, 1'b0);
      end
    end

    for (int i = 0; i < 150; i++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        dividend = W'($urandom);
        divisor  = W'($urandom);
        tick();
        check("gap_done", int'(done), 0);
      end
      run(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
          1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
